// File: rtl/gray_mon_pkg.sv
// gray_mon_pkg: shared state encoding, widths and Gray helper functions for the event monitor
package gray_mon_pkg;

    localparam int GM_W     = 4;
    localparam int GM_TS_W  = 8;
    localparam int GM_REC_W = GM_W + GM_TS_W;
    localparam int FN_W     = 16;
    localparam int PC_W     = $clog2(FN_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_FAULT} state_t;

    // Decode from the MSB down; zero-extended inputs decode to zero-extended results
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [FN_W-1:0] v);
        logic [PC_W-1:0] p;
        p = '0;
        for (int i = 0; i < FN_W; i++) p = p + PC_W'(v[i]);
        return p;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous FIFO with first-word fall-through head and wrap-bit full/empty detection
module event_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             empty, do_pop, do_push;

    assign empty   = wr_q == rd_q;
    assign full_o  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full_o | do_pop);
    assign valid_o = ~empty;
    assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

    // Pointer advance; a pop frees the slot a same-cycle push into a full FIFO lands in
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/gray_event_monitor.sv
// gray_event_monitor: decodes Gray samples, checks single-bit steps, counts events and queues timestamped records
module gray_event_monitor
    import gray_mon_pkg::*;
#(
    parameter int W     = GM_W,
    parameter int TS_W  = GM_TS_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      gray_in,
    input  logic              gray_valid,
    input  logic              det_in,
    input  logic              clr,
    output logic [W-1:0]      bin_out,
    output logic              bin_valid,
    output logic              seq_err,
    output logic              ovf,
    output logic [CNT_W-1:0]  evt_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [W+TS_W-1:0] evt_data,
    output logic              evt_valid,
    input  logic              evt_ready
);

    localparam int REC_W = W + TS_W;

    state_t           state_q, state_d;
    logic [W-1:0]     prev_q, prev_d, bin_q, bin_d, bin_now;
    logic             bin_valid_q, ovf_q, ovf_d;
    logic [TS_W-1:0]  ts_q;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d, err_cnt_q, err_cnt_d;
    logic [FN_W-1:0]  bin_wide;
    logic             evt, illegal, full, pop;

    assign bin_wide = gray2bin(FN_W'(gray_in));
    assign bin_now  = bin_wide[W-1:0];
    assign evt      = det_in & gray_valid;
    assign pop      = evt_valid & evt_ready;
    assign illegal  = gray_valid && state_q != S_IDLE && popcount(FN_W'(gray_in ^ prev_q)) > PC_W'(1);

    // Step-check FSM: first sample after reset is unchecked, a bad step parks in S_FAULT until clr
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (gray_valid) state_d = S_TRACK;
            S_TRACK: if (illegal && !clr) state_d = S_FAULT;
            S_FAULT: if (clr) state_d = S_TRACK;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next state; clr beats same-cycle increments and the overflow flag
    always_comb begin
        prev_d    = gray_valid ? gray_in : prev_q;
        bin_d     = gray_valid ? bin_now : bin_q;
        evt_cnt_d = clr ? '0 : (evt && evt_cnt_q != '1) ? evt_cnt_q + 1'b1 : evt_cnt_q;
        err_cnt_d = clr ? '0 : (illegal && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
        ovf_d     = clr ? 1'b0 : ovf_q | (evt & full & ~pop);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            ts_q        <= '0;
            ovf_q       <= 1'b0;
            evt_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            bin_q       <= bin_d;
            bin_valid_q <= gray_valid;
            ts_q        <= ts_q + 1'b1;
            ovf_q       <= ovf_d;
            evt_cnt_q   <= evt_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    event_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (evt),
        .data_i  ({bin_now, ts_q}),
        .pop_i   (evt_ready),
        .data_o  (evt_data),
        .valid_o (evt_valid),
        .full_o  (full)
    );

    assign bin_out   = bin_q;
    assign bin_valid = bin_valid_q;
    assign seq_err   = state_q == S_FAULT;
    assign ovf       = ovf_q;
    assign evt_cnt   = evt_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule
